// File: rtl/reg_dump_sequencer.sv
// ---------------------------------------------------------------------------
// reg_dump_sequencer
//
// Read-side initiator for the 32-entry register file. A start command latches
// an inclusive index range (5-bit wrap-around), then every index in the range
// is presented on the register-file read port, the combinational read data is
// registered, and the value is streamed out tagged with its index over a
// valid/ready interface. busy_o stays high for the whole dump so the control
// unit can hold off register writes and keep the snapshot coherent.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   start_i          start a dump (only sampled in IDLE)
//   abort_i          synchronous abort back to IDLE, priority over start_i
//   first_reg_i      first index of the range, latched at start
//   last_reg_i       last index of the range (inclusive), latched at start
//   Read_Register_o  address to the register-file read port
//   Read_Data_i      combinational data for Read_Register_o
//   dump_valid_o     dump_data_o / dump_index_o hold a valid beat
//   dump_ready_i     sink accepts the current beat
//   dump_data_o      registered register value
//   dump_index_o     index of dump_data_o
//   busy_o           high while a dump is in progress (ADDR, SEND, DONE)
//   done_o           one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module reg_dump_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [4:0]   first_reg_i,
    input  logic [4:0]   last_reg_i,
    output logic [4:0]   Read_Register_o,
    input  logic [N-1:0] Read_Data_i,
    output logic         dump_valid_o,
    input  logic         dump_ready_i,
    output logic [N-1:0] dump_data_o,
    output logic [4:0]   dump_index_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_SEND,
        S_DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [4:0]     index_q;
    logic [4:0]     last_q;
    logic [N-1:0]   data_q;
    logic [4:0]     beat_index_q;
    logic           handshake;
    logic           at_last;

    // A beat is accepted only while it is actually being offered.
    assign handshake = (state_q == S_SEND) && dump_ready_i;
    assign at_last   = (index_q == last_q);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Abort wins over everything once a dump is running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = abort_i ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (handshake) begin
                    state_d = at_last ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: range latch, index walk and beat capture. The index is left
    // on the last delivered value when the dump ends, so the read port keeps
    // pointing there while idle. The first index goes straight into the
    // counter, so only the last index needs its own register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_q      <= '0;
            last_q       <= '0;
            data_q       <= '0;
            beat_index_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        index_q <= first_reg_i;
                        last_q  <= last_reg_i;
                    end
                end
                S_ADDR: begin
                    // Read data is sampled only here; later register-file
                    // writes cannot disturb the beat being offered.
                    if (!abort_i) begin
                        data_q       <= Read_Data_i;
                        beat_index_q <= index_q;
                    end
                end
                S_SEND: begin
                    if (handshake && !abort_i && !at_last) begin
                        index_q <= index_q + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state, so an asynchronous reset clears them at once.
    always_comb begin
        Read_Register_o = index_q;
        dump_data_o     = data_q;
        dump_index_o    = beat_index_q;
        dump_valid_o    = (state_q == S_SEND);
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_DONE);
    end

endmodule
